// File: rtl/lcd_bus_scheduler.sv
// HD44780 bus scheduler: runs the panel power-up/init sequence, then arbitrates
// two write requesters round-robin and generates the E strobe with programmable timing.
module lcd_bus_scheduler #(
   parameter int INIT_WAIT  = 2000,
   parameter int SETUP_CYC  = 2,
   parameter int PULSE_CYC  = 4,
   parameter int HOLD_CYC   = 2,
   parameter int WAIT_SHORT = 40,
   parameter int WAIT_LONG  = 1600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a_req,
   input  logic       a_rs,
   input  logic [7:0] a_data,
   output logic       a_ack,
   input  logic       b_req,
   input  logic       b_rs,
   input  logic [7:0] b_data,
   output logic       b_ack,
   output logic       busy,
   output logic       init_done,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic [7:0] LCD_DATA
);

   function automatic int imax(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

   localparam int MAX_CYC = imax(imax(imax(INIT_WAIT, WAIT_LONG), imax(WAIT_SHORT, PULSE_CYC)),
                                 imax(SETUP_CYC, HOLD_CYC));
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic [2:0] {
      S_POWERUP,
      S_INIT,
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_WAIT
   } state_t;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h38;
         2'd1:    return 8'h06;
         2'd2:    return 8'h0C;
         default: return 8'h01;
      endcase
   endfunction

   // Clear (0x01) and home (0x02/0x03) need the long busy wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
      return !rs && (d[7:2] == 6'd0) && (d != 8'd0);
   endfunction

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_wait_end;
   logic             r_rs, w_rs_nxt;
   logic [7:0]       r_data, w_data_nxt;
   logic [1:0]       r_idx, w_idx_nxt;
   logic             r_last_b, w_last_b_nxt;
   logic             r_init_done, w_init_done_nxt;
   logic             w_a_grant, w_b_grant;
   logic             r_a_ack, r_b_ack;
   logic             r_e, r_busy;

   always_comb begin
      w_state_nxt     = r_state;
      w_rs_nxt        = r_rs;
      w_data_nxt      = r_data;
      w_idx_nxt       = r_idx;
      w_last_b_nxt    = r_last_b;
      w_init_done_nxt = r_init_done;
      w_a_grant       = 1'b0;
      w_b_grant       = 1'b0;
      w_wait_end      = is_long_cmd(r_rs, r_data) ? CNT_W'(WAIT_LONG - 1) : CNT_W'(WAIT_SHORT - 1);
      case (r_state)
         S_POWERUP: begin
            if (r_cnt == CNT_W'(INIT_WAIT - 1)) w_state_nxt = S_INIT;
         end
         S_INIT: begin
            w_idx_nxt   = 2'd0;
            w_rs_nxt    = 1'b0;
            w_data_nxt  = init_cmd(2'd0);
            w_state_nxt = S_SETUP;
         end
         S_IDLE: begin
            // r_last_b set means B was granted last, so A wins a tie.
            if (a_req && (!b_req || r_last_b)) begin
               w_a_grant    = 1'b1;
               w_last_b_nxt = 1'b0;
               w_rs_nxt     = a_rs;
               w_data_nxt   = a_data;
               w_state_nxt  = S_SETUP;
            end else if (b_req) begin
               w_b_grant    = 1'b1;
               w_last_b_nxt = 1'b1;
               w_rs_nxt     = b_rs;
               w_data_nxt   = b_data;
               w_state_nxt  = S_SETUP;
            end
         end
         S_SETUP: begin
            if (r_cnt == CNT_W'(SETUP_CYC - 1)) w_state_nxt = S_PULSE;
         end
         S_PULSE: begin
            if (r_cnt == CNT_W'(PULSE_CYC - 1)) w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (r_cnt == CNT_W'(HOLD_CYC - 1)) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (r_cnt == w_wait_end) begin
               if (r_init_done) begin
                  w_state_nxt = S_IDLE;
               end else if (r_idx == 2'd3) begin
                  w_state_nxt     = S_IDLE;
                  w_init_done_nxt = 1'b1;
               end else begin
                  w_idx_nxt   = r_idx + 2'd1;
                  w_rs_nxt    = 1'b0;
                  w_data_nxt  = init_cmd(r_idx + 2'd1);
                  w_state_nxt = S_SETUP;
               end
            end
         end
         default: w_state_nxt = S_POWERUP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_POWERUP;
         r_cnt       <= '0;
         r_rs        <= 1'b0;
         r_data      <= 8'h00;
         r_idx       <= 2'd0;
         r_last_b    <= 1'b1;
         r_init_done <= 1'b0;
         r_a_ack     <= 1'b0;
         r_b_ack     <= 1'b0;
         r_e         <= 1'b0;
         r_busy      <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt != r_state)
            r_cnt <= '0;
         else if (r_state != S_IDLE)
            r_cnt <= r_cnt + CNT_W'(1);
         r_rs        <= w_rs_nxt;
         r_data      <= w_data_nxt;
         r_idx       <= w_idx_nxt;
         r_last_b    <= w_last_b_nxt;
         r_init_done <= w_init_done_nxt;
         r_a_ack     <= w_a_grant;
         r_b_ack     <= w_b_grant;
         r_e         <= (w_state_nxt == S_PULSE);
         r_busy      <= (w_state_nxt != S_IDLE);
      end
   end

   assign a_ack     = r_a_ack;
   assign b_ack     = r_b_ack;
   assign busy      = r_busy;
   assign init_done = r_init_done;
   assign LCD_E     = r_e;
   assign LCD_RS    = r_rs;
   assign LCD_RW    = 1'b0;
   assign LCD_DATA  = r_data;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Bench for lcd_bus_scheduler: directed scenarios plus random traffic against a
// timeline model of grants, busy windows and E pulses.
module tb_lcd_bus_scheduler;

   localparam int IW = 10;
   localparam int SC = 1;
   localparam int PC = 2;
   localparam int HC = 1;
   localparam int WS = 4;
   localparam int WL = 12;
   localparam int INIT_LAT   = IW + 3 * (SC + PC + HC + WS) + (SC + PC + HC + WL);
   localparam int INIT_TOTAL = INIT_LAT + 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       a_req = 1'b0, a_rs = 1'b0, b_req = 1'b0, b_rs = 1'b0;
   logic [7:0] a_data = 8'h00, b_data = 8'h00;
   logic       a_ack, b_ack, busy, init_done, LCD_E, LCD_RS, LCD_RW;
   logic [7:0] LCD_DATA;

   lcd_bus_scheduler #(
      .INIT_WAIT(IW), .SETUP_CYC(SC), .PULSE_CYC(PC), .HOLD_CYC(HC),
      .WAIT_SHORT(WS), .WAIT_LONG(WL)
   ) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_rs(a_rs), .a_data(a_data), .a_ack(a_ack),
      .b_req(b_req), .b_rs(b_rs), .b_data(b_data), .b_ack(b_ack),
      .busy(busy), .init_done(init_done),
      .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         rise;
   } wr_t;

   wr_t  wq[$];
   int   order[$];
   int   n_cmp = 0, n_err = 0;
   int   n = 0;
   int   busy_until = 1 << 30;
   int   init_at = 1 << 30;
   int   n_rst = 0;
   int   n_ack_a = 0, n_ack_b = 0, cnt_a = 0;
   bit   last_b = 1'b1;
   bit   prev_init = 1'b0;
   bit   a_auto = 1'b0, b_auto = 1'b0, a_fix = 1'b0, b_fix = 1'b0;
   int   prob = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, n);
      end
   endtask

   function automatic logic [7:0] init_byte(input int k);
      case (k)
         0:       return 8'h38;
         1:       return 8'h06;
         2:       return 8'h0C;
         default: return 8'h01;
      endcase
   endfunction

   function automatic int wait_len(input logic rs, input logic [7:0] d);
      return (!rs && d >= 8'h01 && d <= 8'h03) ? WL : WS;
   endfunction

   function automatic logic [7:0] rand_byte();
      if ($urandom_range(0, 3) == 0) return 8'($urandom_range(1, 3));
      return 8'($urandom_range(0, 255));
   endfunction

   // One clock: sample inputs, advance, update the timeline model, check, then drive requesters.
   task automatic step();
      logic       ra, rb, ars, brs, rs_s, ga, gb, exp_e;
      logic [7:0] ad, bd;
      wr_t        w;
      ra = a_req; rb = b_req; ars = a_rs; brs = b_rs; ad = a_data; bd = b_data; rs_s = reset;
      @(posedge clk);
      #1;
      n++;
      ga = 1'b0;
      gb = 1'b0;
      if (rs_s) begin
         wq.delete();
         busy_until = n + INIT_TOTAL;
         init_at    = busy_until;
         last_b     = 1'b1;
         n_rst      = n;
         for (int k = 0; k < 4; k++) begin
            w.rs = 1'b0; w.data = init_byte(k); w.rise = n + IW + 1 + k * (SC + PC + HC + WS) + SC;
            wq.push_back(w);
         end
      end else if (n - 1 >= busy_until) begin
         ga = ra && (!rb || last_b);
         gb = rb && !ga;
         if (ga) begin
            w.rs = ars; w.data = ad; w.rise = n + SC;
            wq.push_back(w);
            busy_until = n + SC + PC + HC + wait_len(ars, ad);
            last_b = 1'b0;
         end else if (gb) begin
            w.rs = brs; w.data = bd; w.rise = n + SC;
            wq.push_back(w);
            busy_until = n + SC + PC + HC + wait_len(brs, bd);
            last_b = 1'b1;
         end
      end
      while (wq.size() > 0 && n >= wq[0].rise + PC) void'(wq.pop_front());
      exp_e = (wq.size() > 0) && (n >= wq[0].rise);

      chk("a_ack", 32'(a_ack), 32'(ga));
      chk("b_ack", 32'(b_ack), 32'(gb));
      chk("busy", 32'(busy), 32'(n < busy_until));
      chk("init_done", 32'(init_done), 32'(n >= init_at));
      chk("lcd_e", 32'(LCD_E), 32'(exp_e));
      chk("lcd_rw", 32'(LCD_RW), 32'd0);
      if (exp_e) begin
         chk("lcd_rs", 32'(LCD_RS), 32'(wq[0].rs));
         chk("lcd_data", 32'(LCD_DATA), 32'(wq[0].data));
      end
      if (!prev_init && init_done && !rs_s)
         chk("init_lat", 32'(n - (n_rst + 1)), 32'(INIT_LAT));
      prev_init = init_done;

      if (a_ack) begin n_ack_a = n; cnt_a++; order.push_back(0); end
      if (b_ack) begin n_ack_b = n; order.push_back(1); end

      if (a_ack) a_req = 1'b0;
      else if (!a_req && a_auto && $urandom_range(0, 99) < prob) begin
         a_req = 1'b1;
         a_rs   = a_fix ? 1'b1 : 1'($urandom_range(0, 1));
         a_data = a_fix ? 8'h31 : rand_byte();
      end
      if (b_ack) b_req = 1'b0;
      else if (!b_req && b_auto && $urandom_range(0, 99) < prob) begin
         b_req = 1'b1;
         b_rs   = b_fix ? 1'b1 : 1'($urandom_range(0, 1));
         b_data = b_fix ? 8'h32 : rand_byte();
      end
   endtask

   task automatic wait_idle(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         step();
         if (!busy && !a_req && !b_req) ok = 1'b1;
      end
      if (!ok) chk(tag, 32'd0, 32'd1);
   endtask

   initial begin
      bit got;
      int nb;

      // Reset then init with no traffic.
      reset = 1'b1;
      step();
      chk("rst_data", 32'(LCD_DATA), 32'h00);
      chk("rst_rs", 32'(LCD_RS), 32'd0);
      step();
      step();
      reset = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin step(); if (init_done) got = 1'b1; end
      chk("init_reached", 32'(got), 32'd1);

      // Simultaneous A/B requests with immediate re-request: strict alternation.
      order.delete();
      a_fix = 1'b1; b_fix = 1'b1; a_auto = 1'b1; b_auto = 1'b1; prob = 100;
      a_req = 1'b1; a_rs = 1'b1; a_data = 8'h31;
      b_req = 1'b1; b_rs = 1'b1; b_data = 8'h32;
      repeat (40) step();
      a_auto = 1'b0; b_auto = 1'b0; a_fix = 1'b0; b_fix = 1'b0;
      chk("rr_count", 32'(order.size() >= 4), 32'd1);
      if (order.size() >= 4)
         for (int i = 0; i < 4; i++) chk("rr_order", 32'(order[i]), 32'(i % 2));
      wait_idle("rr_drain");

      // Single A character write.
      cnt_a = 0;
      a_req = 1'b1; a_rs = 1'b1; a_data = 8'h41;
      repeat (20) step();
      chk("single_acks", 32'(cnt_a), 32'd1);

      // Long command from B, A requests during its busy wait.
      b_req = 1'b1; b_rs = 1'b0; b_data = 8'h01;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin step(); if (b_ack) got = 1'b1; end
      chk("long_b_ack", 32'(got), 32'd1);
      nb = n_ack_b;
      repeat (3) step();
      a_req = 1'b1; a_rs = 1'b1; a_data = 8'h5A;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin step(); if (a_ack) got = 1'b1; end
      chk("long_a_ack", 32'(got), 32'd1);
      chk("long_gap", 32'(n_ack_a - nb), 32'(1 + SC + PC + HC + WL));
      wait_idle("long_drain");

      // A request held from reset is acked one cycle after IDLE is entered.
      a_req = 1'b1; a_rs = 1'b1; a_data = 8'h55;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin step(); if (a_ack) got = 1'b1; end
      chk("init_req_ack", 32'(got), 32'd1);
      chk("init_req_edge", 32'(n_ack_a - n_rst), 32'(INIT_TOTAL + 1));
      wait_idle("init_req_drain");

      // Reset while E is high.
      b_req = 1'b1; b_rs = 1'b1; b_data = 8'h42;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin step(); if (LCD_E) got = 1'b1; end
      chk("rp_pulse_seen", 32'(got), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rp_e", 32'(LCD_E), 32'd0);
      chk("rp_busy", 32'(busy), 32'd1);
      chk("rp_init", 32'(init_done), 32'd0);
      chk("rp_data", 32'(LCD_DATA), 32'h00);
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin step(); if (init_done) got = 1'b1; end
      chk("rp_reinit", 32'(got), 32'd1);

      // Random traffic with rare resets.
      a_auto = 1'b1; b_auto = 1'b1; prob = 20;
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 799) == 0);
         step();
      end
      reset = 1'b0;
      a_auto = 1'b0; b_auto = 1'b0;
      wait_idle("rand_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lcd_bus_scheduler.md
# lcd_bus_scheduler

Shares one HD44780-style character LCD bus between two independent requesters (A and B). It also owns the panel power-up and initialisation sequence. The block generates its own enable (E) pulse with programmable setup, pulse, hold and busy-wait timing, so the LCD no longer has to be clocked directly from the system clock. It sits between the text-producing logic (message writers, status writers) and the LCD pins.

## Interface
Parameters:
- INIT_WAIT, 2000: cycles to wait after reset before the first init command.
- SETUP_CYC, 2: cycles RS/DATA are stable with E low before E rises.
- PULSE_CYC, 4: cycles E is held high.
- HOLD_CYC, 2: cycles RS/DATA are held after E falls.
- WAIT_SHORT, 40: post-write busy wait for ordinary commands and characters.
- WAIT_LONG, 1600: post-write busy wait for clear/home commands.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  requester A write request; level, held until a_ack.
- a_rs  in  1  A register select (0 = command, 1 = character).
- a_data  in  8  A write byte.
- a_ack  out  1  one-cycle acceptance pulse to A.
- b_req, b_rs, b_data, b_ack: same as A, for requester B.
- busy  out  1  high whenever the scheduler is not in IDLE.
- init_done  out  1  high once the init sequence completes; stays high until reset.
- LCD_E  out  1  LCD enable strobe.
- LCD_RS  out  1  LCD register select.
- LCD_RW  out  1  LCD read/write; the block only writes, so this is always 0.
- LCD_DATA  out  8  LCD data bus.

## Operation
- States: POWERUP, INIT, IDLE, SETUP, PULSE, HOLD, WAIT.
- POWERUP: counts INIT_WAIT cycles, then goes to INIT.
- INIT: issues four commands in order through SETUP/PULSE/HOLD/WAIT, with RS=0:
  - 0x38 (function set)
  - 0x06 (entry mode)
  - 0x0C (display on)
  - 0x01 (clear)
- After WAIT of the last init command: init_done goes to 1 and the state goes to IDLE.
- IDLE: samples a_req and b_req.
  - Only one request high: it is granted.
  - Both high: round-robin; the requester not granted last time wins.
  - After reset the last-grant marker points to B, so A wins the first tie.
- Grant: latches the requester's rs/data into internal registers and enters SETUP. The matching x_ack is high for exactly that first SETUP cycle.
- SETUP: LCD_RS/LCD_DATA driven from the latch, E=0, for SETUP_CYC cycles.
- PULSE: E=1 for PULSE_CYC cycles.
- HOLD: E=0, bus unchanged, for HOLD_CYC cycles.
- WAIT: E=0, bus unchanged.
  - Lasts WAIT_LONG cycles if rs=0 and data[7:2]==0 with data≠0 (i.e. 0x01, 0x02 or 0x03).
  - Otherwise lasts WAIT_SHORT cycles.
  - Returns to IDLE when done.
- Requests seen outside IDLE are ignored; no ack is given. This includes POWERUP and INIT.
- Requester contract:
  - Hold req, rs and data stable until ack.
  - Deassert req in the ack cycle. A req still high when the scheduler returns to IDLE counts as a new request.
- Phase counter: one shared counter, cleared on every state change.

## Timing
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, a_ack=0, b_ack=0, busy=1, init_done=0, state=POWERUP, last grant=B.
- All outputs are registered.
- Grant latency: a request present in an IDLE cycle gets its ack on the next cycle.
- LCD_E is high for exactly PULSE_CYC cycles per write. It rises SETUP_CYC cycles after the grant edge.
- Occupancy per write, from SETUP entry to IDLE re-entry: SETUP_CYC+PULSE_CYC+HOLD_CYC+WAIT cycles.
- With defaults, a character write takes 48 cycles and a clear takes 1608.
- busy is high from the grant edge through the last WAIT cycle, and low only in IDLE.
- Reset asserted mid-transaction: on the next edge E drops to 0, the latched write is discarded, no ack is issued, and the full POWERUP and INIT sequence reruns.
- init_done never deasserts except on reset.

## Test plan
Parameters for the bench: INIT_WAIT=10, SETUP_CYC=1, PULSE_CYC=2, HOLD_CYC=1, WAIT_SHORT=4, WAIT_LONG=12.
- **Reset then idle:** after reset, LCD_DATA shows 0x38, 0x06, 0x0C, 0x01 with RS=0. There are exactly 4 E pulses, each 2 cycles wide. init_done rises 10+3×8+16 cycles after reset release.
- **Single A write:** a_req with a_rs=1, a_data=0x41 after init_done. a_ack pulses once, one cycle later. LCD_RS=1, LCD_DATA=0x41, and E is high for 2 cycles. busy is low again 8 cycles after the grant.
- **Simultaneous A and B, repeated:** both request 0x31 and 0x32 respectively, re-requesting after each ack. The grant order is A, B, A, B, and no ack is issued while busy=1.
- **Long command:** B sends rs=0, 0x01. The WAIT phase lasts 12 cycles (busy high for 16). A request from A during the wait is acked only after busy falls.
- **Request during init:** a_req held high from reset. No a_ack before init_done. The ack arrives one cycle after IDLE is entered.
- **Reset during PULSE:** reset asserted while LCD_E=1. On the next edge LCD_E=0, busy=1, init_done=0. The init sequence restarts from POWERUP.
